// File: rtl/io_pkg.sv
// Shared IO definitions: memory-mapped input addresses, debounce state
// encoding and the shortened debounce length used in simulation.
package io_pkg;

  localparam logic [31:0] DATA_ADDR   = 32'hFFFF_FFC0;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FFC8;
  localparam logic [31:0] LIVE_ADDR   = 32'hFFFF_FFCC;

  localparam logic [19:0] SIM_DEBOUNCE_CYCLES = 20'd4;

  typedef logic [1:0] dbState_t;
  localparam dbState_t DB_LOW       = 2'd0;
  localparam dbState_t DB_WAIT_HIGH = 2'd1;
  localparam dbState_t DB_HIGH      = 2'd2;
  localparam dbState_t DB_WAIT_LOW  = 2'd3;

endpackage

// File: rtl/io_input_reader_if.sv
// CPU load port of the input block: address plus one-cycle read strobe,
// read data returned combinationally in the same cycle.
interface io_input_reader_if;

  // Handshake: the CPU drives address and pulses ioRead for exactly one
  // cycle per load; there is no ready/stall, dataIOInput is valid in that
  // same cycle and read side effects take effect at the closing clk edge.
  logic [31:0] address;
  logic        ioRead;
  logic [31:0] dataIOInput;

  modport master (output address, output ioRead, input dataIOInput);
  modport slave  (input address, input ioRead, output dataIOInput);

endinterface

// File: rtl/io_debounce.sv
// Confirm-button synchronizer and debounce FSM; emits the debounced level
// and a single press pulse per accepted press.
module io_debounce
  import io_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     confirmation,
  output logic     level,
  output logic     press,
  output dbState_t state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 20'd1);

  logic          cfMeta;
  logic          cfSync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfMeta <= 1'b0;
      cfSync <= 1'b0;
      state  <= DB_LOW;
      cnt    <= '0;
    end else begin
      cfMeta <= confirmation;
      cfSync <= cfMeta;
      case (state)
        DB_LOW: begin
          if (cfSync) begin
            state <= DB_WAIT_HIGH;
            cnt   <= CW'(1);
          end
        end
        DB_WAIT_HIGH: begin
          if (!cfSync) begin
            state <= DB_LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= DB_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DB_HIGH: begin
          if (!cfSync) begin
            state <= DB_WAIT_LOW;
            cnt   <= CW'(1);
          end
        end
        default: begin
          // DB_WAIT_LOW: release must be stable just as long as a press
          if (cfSync) begin
            state <= DB_HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= DB_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Pulse coincides with the edge that moves WAIT_HIGH -> HIGH
  assign press = (state == DB_WAIT_HIGH) && cfSync && (cnt == LAST);
  assign level = (state == DB_HIGH) || (state == DB_WAIT_LOW);

endmodule

// File: rtl/io_input_reader.sv
// Memory-mapped switch reader: captures a switch snapshot on each debounced
// confirm press and serves it to CPU loads with read-to-clear status.
module io_input_reader
  import io_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              switchInput,
  input  logic                     confirmation,
  io_input_reader_if.slave         bus,
  output logic                     ready,
  output logic                     overrun,
  output dbState_t                 dbgState,
  output logic                     dbgLevel
);

  logic [15:0] swMeta;
  logic [15:0] swSync;
  logic [15:0] dataReg;
  logic        readyReg;
  logic        overrunReg;
  logic        press;
  logic        dataRead;
  logic        statusRead;
  logic [31:0] rdata;

  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .confirmation (confirmation),
    .level        (dbgLevel),
    .press        (press),
    .state        (dbgState)
  );

  assign dataRead   = bus.ioRead && (bus.address == DATA_ADDR);
  assign statusRead = bus.ioRead && (bus.address == STATUS_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      swMeta     <= '0;
      swSync     <= '0;
      dataReg    <= '0;
      readyReg   <= 1'b0;
      overrunReg <= 1'b0;
    end else begin
      swMeta <= switchInput;
      swSync <= swMeta;
      // A capture beats a simultaneous DATA read: the new snapshot stays pending
      if (press) begin
        dataReg  <= swSync;
        readyReg <= 1'b1;
      end else if (dataRead) begin
        readyReg <= 1'b0;
      end
      // Overrun set wins over a simultaneous STATUS clear
      if (press && readyReg && !dataRead) begin
        overrunReg <= 1'b1;
      end else if (statusRead) begin
        overrunReg <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (!rst) begin
      case (bus.address)
        DATA_ADDR:   rdata = {16'h0, dataReg};
        STATUS_ADDR: rdata = {30'h0, overrunReg, readyReg};
        LIVE_ADDR:   rdata = {16'h0, swSync};
        default:     rdata = 32'h0;
      endcase
    end
  end

  assign bus.dataIOInput = rdata;
  assign ready           = readyReg;
  assign overrun         = overrunReg;

endmodule

// File: tb/tb_io_input_reader.sv
// Directed bench for io_input_reader with a 4-cycle debounce.
module tb_io_input_reader;
  import io_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] switchInput;
  logic        confirmation;
  logic        ready;
  logic        overrun;
  dbState_t    dbgState;
  logic        dbgLevel;
  int          tests;
  int          failures;

  io_input_reader_if bus ();

  io_input_reader #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .switchInput  (switchInput),
    .confirmation (confirmation),
    .bus          (bus),
    .ready        (ready),
    .overrun      (overrun),
    .dbgState     (dbgState),
    .dbgLevel     (dbgLevel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus.address = addr;
    bus.ioRead  = 1'b0;
    #1;
    check(tag, bus.dataIOInput, exp);
  endtask

  task automatic cpuRead(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus.address = addr;
    bus.ioRead  = 1'b1;
    #1;
    check(tag, bus.dataIOInput, exp);
    tick();
    bus.ioRead = 1'b0;
  endtask

  task automatic pressButton(input logic [15:0] sw);
    switchInput  = sw;
    confirmation = 1'b1;
    repeat (8) tick();
    confirmation = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    tests        = 0;
    failures     = 0;
    rst          = 1'b1;
    switchInput  = 16'hFFFF;
    confirmation = 1'b1;
    bus.address  = DATA_ADDR;
    bus.ioRead   = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_data", bus.dataIOInput, 32'h0);
    check("rst_state", {30'h0, dbgState}, {30'h0, DB_LOW});

    // confirm held through reset: capture only after 2 sync + 4 stable cycles
    rst = 1'b0;
    repeat (5) tick();
    check("post_rst_ready_early", {31'h0, ready}, 32'h0);
    tick();
    check("post_rst_ready", {31'h0, ready}, 32'h1);
    peek(DATA_ADDR, 32'h0000_FFFF, "post_rst_data");
    confirmation = 1'b0;
    repeat (8) tick();
    check("post_rst_level", {31'h0, dbgLevel}, 32'h0);
    cpuRead(DATA_ADDR, 32'h0000_FFFF, "post_rst_read");
    check("post_rst_cleared", {31'h0, ready}, 32'h0);

    // clean press
    switchInput = 16'h00A5;
    repeat (2) tick();
    confirmation = 1'b1;
    repeat (5) tick();
    check("clean_ready_early", {31'h0, ready}, 32'h0);
    tick();
    check("clean_ready", {31'h0, ready}, 32'h1);
    check("clean_level", {31'h0, dbgLevel}, 32'h1);
    repeat (4) tick();
    check("clean_no_repeat_ovr", {31'h0, overrun}, 32'h0);
    confirmation = 1'b0;
    cpuRead(DATA_ADDR, 32'h0000_00A5, "clean_data");
    check("clean_cleared", {31'h0, ready}, 32'h0);
    repeat (8) tick();
    check("clean_state_low", {30'h0, dbgState}, {30'h0, DB_LOW});

    // bounce 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      confirmation = (i % 2 == 0);
      tick();
    end
    confirmation = 1'b0;
    repeat (8) tick();
    check("bounce_ready", {31'h0, ready}, 32'h0);
    check("bounce_state", {30'h0, dbgState}, {30'h0, DB_LOW});

    // 3-cycle glitch
    confirmation = 1'b1;
    repeat (3) tick();
    check("glitch_wait_high", {30'h0, dbgState}, {30'h0, DB_WAIT_HIGH});
    confirmation = 1'b0;
    repeat (8) tick();
    check("glitch_ready", {31'h0, ready}, 32'h0);
    check("glitch_state", {30'h0, dbgState}, {30'h0, DB_LOW});

    // overrun
    pressButton(16'h1111);
    check("ovr_first_ready", {31'h0, ready}, 32'h1);
    check("ovr_first_overrun", {31'h0, overrun}, 32'h0);
    pressButton(16'h2222);
    check("ovr_overrun", {31'h0, overrun}, 32'h1);
    peek(DATA_ADDR, 32'h0000_2222, "ovr_data_peek");
    cpuRead(STATUS_ADDR, 32'h3, "ovr_status_3");
    cpuRead(STATUS_ADDR, 32'h1, "ovr_status_1");
    cpuRead(DATA_ADDR, 32'h0000_2222, "ovr_data_read");
    cpuRead(STATUS_ADDR, 32'h0, "ovr_status_0");

    // DATA read on the same edge as the press pulse
    pressButton(16'h1234);
    check("coll_pre_ready", {31'h0, ready}, 32'h1);
    switchInput  = 16'h5678;
    confirmation = 1'b1;
    repeat (5) tick();
    cpuRead(DATA_ADDR, 32'h0000_1234, "coll_data_old");
    check("coll_ready", {31'h0, ready}, 32'h1);
    check("coll_overrun", {31'h0, overrun}, 32'h0);
    peek(DATA_ADDR, 32'h0000_5678, "coll_data_new");
    tick();
    check("noread_ready", {31'h0, ready}, 32'h1);
    confirmation = 1'b0;
    repeat (8) tick();
    cpuRead(DATA_ADDR, 32'h0000_5678, "coll_data_read");

    // STATUS read on the same edge as an overrunning capture: set wins
    pressButton(16'h0F0F);
    switchInput  = 16'hF0F0;
    confirmation = 1'b1;
    repeat (5) tick();
    cpuRead(STATUS_ADDR, 32'h1, "scoll_status_pre");
    check("scoll_overrun", {31'h0, overrun}, 32'h1);
    confirmation = 1'b0;
    repeat (8) tick();
    cpuRead(STATUS_ADDR, 32'h3, "scoll_status_3");
    cpuRead(DATA_ADDR, 32'h0000_F0F0, "scoll_data");
    cpuRead(STATUS_ADDR, 32'h0, "scoll_status_0");

    // live switch path and unmapped address
    switchInput = 16'hABCD;
    bus.address = LIVE_ADDR;
    tick();
    peek(LIVE_ADDR, 32'h0000_F0F0, "live_lag1");
    tick();
    peek(LIVE_ADDR, 32'h0000_ABCD, "live_lag2");
    peek(32'hFFFF_FFC4, 32'h0, "unmapped");
    check("live_no_ready", {31'h0, ready}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
